// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg -- shared definitions for the Hack CPU core.
//
// Contents:
//   state_e      control FSM states of hack_core
//   *_BIT/_MSB   bit positions of the fields inside a C-instruction word
//   DEST_*       bit positions inside the latched 3-bit destination field
//   JMP_*        bit positions inside the latched 3-bit jump field
//   ALU_*        bit positions inside the latched 6-bit ALU control field
//   jump_taken   jump condition from the jump field and the ALU flags
// -----------------------------------------------------------------------------
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    MEM_READ   = 3'd2,
    MEM_FETCH  = 3'd3,
    WRITE_BACK = 3'd4,
    HALT       = 3'd5
  } state_e;

  // C-instruction layout (low 13 bits; the MSB of the word marks a C-instr)
  localparam int A_BIT = 12;  // 1: y operand comes from memory (M), 0: from A
  localparam int C_MSB = 11;
  localparam int C_LSB = 6;
  localparam int D_MSB = 5;
  localparam int D_LSB = 3;
  localparam int J_MSB = 2;
  localparam int J_LSB = 0;

  // Destination field {d1, d2, d3}
  localparam int DEST_A = 2;
  localparam int DEST_D = 1;
  localparam int DEST_M = 0;

  // Jump field {j1, j2, j3}
  localparam int JMP_NEG = 2;
  localparam int JMP_ZR  = 1;
  localparam int JMP_POS = 0;

  // ALU control field {zx, nx, zy, ny, f, no}
  localparam int ALU_ZX = 5;
  localparam int ALU_NX = 4;
  localparam int ALU_ZY = 3;
  localparam int ALU_NY = 2;
  localparam int ALU_F  = 1;
  localparam int ALU_NO = 0;

  function automatic logic jump_taken(input logic [2:0] j, input logic neg, input logic zero);
    return (j[JMP_NEG] & neg) | (j[JMP_ZR] & zero) | (j[JMP_POS] & ~neg & ~zero);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// -----------------------------------------------------------------------------
// hack_alu -- combinational Hack ALU at DATA_W bits.
//
// Ports:
//   x_i     [DATA_W-1:0]  x operand (D register)
//   y_i     [DATA_W-1:0]  y operand (A register or memory word)
//   ctrl_i  [5:0]         {zx, nx, zy, ny, f, no}
//   out_o   [DATA_W-1:0]  result; addition wraps modulo 2^DATA_W
//   zero_o                result is all zeros
//   neg_o                 result MSB
// -----------------------------------------------------------------------------
module hack_alu
  import hack_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [5:0]        ctrl_i,
  output logic [DATA_W-1:0] out_o,
  output logic              zero_o,
  output logic              neg_o
);

  logic [DATA_W-1:0] x_zero;
  logic [DATA_W-1:0] x_pre;
  logic [DATA_W-1:0] y_zero;
  logic [DATA_W-1:0] y_pre;
  logic [DATA_W-1:0] fn_out;

  always_comb begin
    // Operand pre-processing: optional zeroing, then optional inversion
    x_zero = ctrl_i[ALU_ZX] ? '0 : x_i;
    x_pre  = ctrl_i[ALU_NX] ? ~x_zero : x_zero;
    y_zero = ctrl_i[ALU_ZY] ? '0 : y_i;
    y_pre  = ctrl_i[ALU_NY] ? ~y_zero : y_zero;

    // Function select, then optional output inversion
    fn_out = ctrl_i[ALU_F] ? (x_pre + y_pre) : (x_pre & y_pre);
    out_o  = ctrl_i[ALU_NO] ? ~fn_out : fn_out;

    zero_o = (out_o == '0);
    neg_o  = out_o[DATA_W-1];
  end

endmodule

// File: rtl/hack_core.sv
// -----------------------------------------------------------------------------
// hack_core -- multi-cycle Hack CPU with a wait-stated shared memory region.
//
// Build option:
//   HACK_CORE_SPEC_FETCH_EN  when defined, a non-jumping commit goes straight
//                            to DECODE using the instruction already fetched
//                            at pc+1; when undefined every commit returns to
//                            FETCH (one extra cycle, identical results).
//
// Parameters:
//   DATA_W       word width of instruction, A, D, pc and memory (>= 16)
//   SLOW_BASE    lowest address of the slow/shared memory region
//   SLOW_LIMIT   highest address of the slow region, inclusive
//   WAIT_CYCLES  settle cycles after mem_busy falls before read data is valid (0..7)
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   instr        ROM word at address pc, valid one cycle after pc changes
//   mem_busy     slow region currently owned by another master
//   mem_rdata    memory read data for mem_addr
//   halt_req     stop at the next instruction boundary (FETCH)
//   mem_we       write strobe, combinational, one cycle per committed write
//   mem_addr     always the A register
//   mem_wdata    ALU result
//   pc           ROM fetch address (registered)
//   retire       one-cycle pulse after each completed instruction
//   halted       high while in HALT
//   dbg_state    current FSM state
//
// Memory handshake: the slow region is usable only while mem_busy is low.
// A read waits for mem_busy low and then counts WAIT_CYCLES more cycles
// (ignoring mem_busy) before sampling mem_rdata. A write to the slow region
// stalls in WRITE_BACK until mem_busy is low, and mem_we is asserted only in
// the single cycle in which the write commits.
// -----------------------------------------------------------------------------
module hack_core
  import hack_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int unsigned SLOW_BASE   = 32'h4000,
  parameter int unsigned SLOW_LIMIT  = 32'h5FFF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  output state_e            dbg_state
);

  localparam logic [DATA_W-1:0] SLOW_LO = DATA_W'(SLOW_BASE);
  localparam logic [DATA_W-1:0] SLOW_HI = DATA_W'(SLOW_LIMIT);
  localparam logic [3:0]        WAIT_N  = 4'(WAIT_CYCLES);
  localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};

  // Architectural and pipeline registers
  state_e            state_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] areg_q;
  logic [DATA_W-1:0] dreg_q;
  logic [DATA_W-1:0] alu_x_q;
  logic [DATA_W-1:0] alu_y_q;
  logic [5:0]        comp_q;
  logic [2:0]        dest_q;
  logic [2:0]        jmp_q;
  // 0: still waiting for mem_busy to fall; 1..WAIT_N: settle cycle number
  logic [3:0]        wait_q;
  logic              retire_q;
  logic              halted_q;

  // ALU and derived control
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic              alu_neg;
  logic              slow_access;
  logic              wb_commit;
  logic              do_jump;
  logic              is_c_instr;
  logic              unused_instr_bits;

  hack_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .x_i    (alu_x_q),
    .y_i    (alu_y_q),
    .ctrl_i (comp_q),
    .out_o  (alu_out),
    .zero_o (alu_zero),
    .neg_o  (alu_neg)
  );

  // Bits between the C-instr marker and the a-bit carry no meaning
  assign unused_instr_bits = ^instr[DATA_W-2:A_BIT+1];
  assign is_c_instr        = instr[DATA_W-1];

  always_comb begin
    slow_access = (areg_q >= SLOW_LO) && (areg_q <= SLOW_HI);
    // Reset is folded in so a stalled write that becomes free in the reset
    // cycle is abandoned rather than strobed out.
    wb_commit   = !reset && (state_q == WRITE_BACK) &&
                  (!dest_q[DEST_M] || !slow_access || !mem_busy);
    do_jump     = jump_taken(jmp_q, alu_neg, alu_zero);
  end

  assign mem_we    = wb_commit && dest_q[DEST_M];
  assign mem_addr  = areg_q;
  assign mem_wdata = alu_out;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      areg_q   <= '0;
      dreg_q   <= '0;
      alu_x_q  <= '0;
      alu_y_q  <= '0;
      comp_q   <= '0;
      dest_q   <= '0;
      jmp_q    <= '0;
      wait_q   <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (halt_req) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= DECODE;
          end
        end

        HALT: begin
          if (!halt_req) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
          end
        end

        DECODE: begin
          pc_q <= pc_q + ONE;
          if (!is_c_instr) begin
            areg_q   <= instr;
            retire_q <= 1'b1;
            state_q  <= FETCH;
          end else begin
            comp_q  <= instr[C_MSB:C_LSB];
            dest_q  <= instr[D_MSB:D_LSB];
            jmp_q   <= instr[J_MSB:J_LSB];
            alu_x_q <= dreg_q;
            if (instr[A_BIT]) begin
              state_q <= MEM_READ;
            end else begin
              alu_y_q <= areg_q;
              state_q <= WRITE_BACK;
            end
          end
        end

        MEM_READ: begin
          if (!slow_access) begin
            state_q <= MEM_FETCH;
          end else if (wait_q == 4'd0) begin
            // The first cycle with mem_busy low is settle cycle zero
            if (!mem_busy) begin
              if (WAIT_N == 4'd0) begin
                state_q <= MEM_FETCH;
              end else begin
                wait_q <= 4'd1;
              end
            end
          end else if (wait_q == WAIT_N) begin
            state_q <= MEM_FETCH;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end

        MEM_FETCH: begin
          alu_y_q <= mem_rdata;
          wait_q  <= 4'd0;
          state_q <= WRITE_BACK;
        end

        WRITE_BACK: begin
          if (wb_commit) begin
            if (dest_q[DEST_A]) areg_q <= alu_out;
            if (dest_q[DEST_D]) dreg_q <= alu_out;
            retire_q <= 1'b1;
            if (do_jump) begin
              // Jump target is A as it was before this instruction's update
              pc_q    <= areg_q;
              state_q <= FETCH;
            end else begin
`ifdef HACK_CORE_SPEC_FETCH_EN
              // pc advanced in DECODE, so instr already holds the next word
              state_q <= DECODE;
`else
              state_q <= FETCH;
`endif
            end
          end
        end

        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_core.sv
// -----------------------------------------------------------------------------
// tb_hack_core -- self-checking bench for hack_core (16-bit instance plus a
// 24-bit instance for wrap-around). Expected memory writes are queued before
// each program runs and popped by a write monitor.
// -----------------------------------------------------------------------------
module tb_hack_core;
  import hack_pkg::*;

  localparam int WAIT_CYC = 2;
`ifdef HACK_CORE_SPEC_FETCH_EN
  localparam int C_TO_A_GAP = 1;
  localparam logic [15:0] HALT_PC = 16'd3;
`else
  localparam int C_TO_A_GAP = 2;
  localparam logic [15:0] HALT_PC = 16'd2;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 16-bit DUT ----------------
  logic [15:0] instr;
  logic        mem_busy;
  logic [15:0] mem_rdata;
  logic        halt_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] pc;
  logic        retire;
  logic        halted;
  state_e      dbg_state;

  hack_core #(
    .DATA_W      (16),
    .SLOW_BASE   (32'h4000),
    .SLOW_LIMIT  (32'h5FFF),
    .WAIT_CYCLES (WAIT_CYC)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_busy  (mem_busy),
    .mem_rdata (mem_rdata),
    .halt_req  (halt_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .pc        (pc),
    .retire    (retire),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  // ---------------- 24-bit DUT ----------------
  logic        reset24;
  logic [23:0] instr24;
  logic        busy24;
  logic [23:0] rdata24;
  logic        halt24;
  logic        we24;
  logic [23:0] addr24;
  logic [23:0] wdata24;
  logic [23:0] pc24;
  logic        retire24;
  logic        halted24;
  state_e      state24;

  hack_core #(
    .DATA_W (24)
  ) u_dut24 (
    .clk       (clk),
    .reset     (reset24),
    .instr     (instr24),
    .mem_busy  (busy24),
    .mem_rdata (rdata24),
    .halt_req  (halt24),
    .mem_we    (we24),
    .mem_addr  (addr24),
    .mem_wdata (wdata24),
    .pc        (pc24),
    .retire    (retire24),
    .halted    (halted24),
    .dbg_state (state24)
  );

  // ---------------- ROM models (word valid one cycle after pc) ----------------
  logic [15:0] rom [0:63];
  always @(posedge clk) instr <= rom[pc[5:0]];

  function automatic logic [15:0] c16(input logic a, input logic [5:0] c,
                                      input logic [2:0] d, input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  function automatic logic [23:0] c24(input logic a, input logic [5:0] c,
                                      input logic [2:0] d, input logic [2:0] j);
    return {1'b1, 10'd0, a, c, d, j};
  endfunction

  function automatic logic [23:0] rom24(input logic [23:0] a);
    case (a)
      24'd0:       return c24(1'b0, 6'b111010, 3'b100, 3'b000); // A=-1
      24'd1:       return c24(1'b0, 6'b110111, 3'b010, 3'b010); // D=A+1;JEQ
      24'hFFFFFF:  return c24(1'b0, 6'b001100, 3'b001, 3'b000); // M=D
      default:     return 24'd0;
    endcase
  endfunction
  always @(posedge clk) instr24 <= rom24(pc24);

  // ---------------- scoreboard ----------------
  int total;
  int bad;
  int cyc;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%h wdata=%h, required no write", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          bad++;
          $display("FAIL write_data: addr=%h wdata=%h, required addr=%h wdata=%h",
                   mem_addr, mem_wdata, exp_w[31:16], exp_w[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_prog;
    reset    = 1'b1;
    mem_busy = 1'b0;
    halt_req = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    exp_q.delete();
  endtask

  task automatic release_reset;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_retires(input int n, input string nm);
    int got;
    int k;
    got = 0;
    k = 0;
    while (got < n && k < 60) begin
      tick();
      k++;
      if (retire === 1'b1) got++;
    end
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL %s: retired %0d in 60 cycles, required %0d", nm, got, n);
    end
  endtask

  task automatic wait_state(input state_e st, input string nm);
    int k;
    k = 0;
    while (dbg_state !== st && k < 40) begin
      tick();
      k++;
    end
    total++;
    if (dbg_state !== st) begin
      bad++;
      $display("FAIL %s: state=%0d, required %0d within 40 cycles", nm, dbg_state, st);
    end
  endtask

  task automatic check_queue_empty(input string nm);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected writes missing, required 0", nm, exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    begin_prog();
    total += 6;
    if (pc !== 16'd0)          begin bad++; $display("FAIL reset_pc: %h, required 0000", pc); end
    if (mem_addr !== 16'd0)    begin bad++; $display("FAIL reset_addr: %h, required 0000", mem_addr); end
    if (mem_we !== 1'b0)       begin bad++; $display("FAIL reset_we: %b, required 0", mem_we); end
    if (retire !== 1'b0)       begin bad++; $display("FAIL reset_retire: %b, required 0", retire); end
    if (halted !== 1'b0)       begin bad++; $display("FAIL reset_halted: %b, required 0", halted); end
    if (dbg_state !== FETCH)   begin bad++; $display("FAIL reset_state: %0d, required FETCH", dbg_state); end
  endtask

  task automatic test_basic_alu;
    int c1, c2, c3;
    begin_prog();
    rom[0] = 16'd5;
    rom[1] = c16(1'b0, 6'b110000, 3'b010, 3'b000); // D=A
    rom[2] = 16'd7;
    rom[3] = c16(1'b0, 6'b000010, 3'b010, 3'b000); // D=D+A
    rom[4] = 16'd0;
    rom[5] = c16(1'b0, 6'b001100, 3'b001, 3'b000); // M=D
    rom[6] = 16'd6;
    rom[7] = c16(1'b0, 6'b101010, 3'b000, 3'b111); // 0;JMP
    exp_q.push_back({16'h0000, 16'd12});
    release_reset();
    wait_retires(1, "basic_r1");
    c1 = cyc;
    wait_retires(1, "basic_r2");
    c2 = cyc;
    wait_retires(1, "basic_r3");
    c3 = cyc;
    total += 2;
    if (c2 - c1 != 3) begin
      bad++; $display("FAIL a_to_c_gap: %0d cycles, required 3", c2 - c1);
    end
    if (c3 - c2 != C_TO_A_GAP) begin
      bad++; $display("FAIL c_to_a_gap: %0d cycles, required %0d", c3 - c2, C_TO_A_GAP);
    end
    wait_retires(3, "basic_rest");
    check_queue_empty("basic_write");
  endtask

  task automatic test_slow_read;
    int k;
    begin_prog();
    mem_busy  = 1'b1;
    mem_rdata = 16'hBEEF;
    rom[0] = 16'h4000;
    rom[1] = c16(1'b1, 6'b110000, 3'b010, 3'b000); // D=M
    rom[2] = 16'd0;
    rom[3] = c16(1'b0, 6'b001100, 3'b001, 3'b000); // M=D
    rom[4] = 16'd4;
    rom[5] = c16(1'b0, 6'b101010, 3'b000, 3'b111); // 0;JMP
    exp_q.push_back({16'h0000, 16'hBEEF});
    release_reset();
    wait_state(MEM_READ, "slow_read_enter");
    repeat (5) tick();
    total++;
    if (dbg_state !== MEM_READ) begin
      bad++; $display("FAIL slow_read_busy_hold: state=%0d, required MEM_READ", dbg_state);
    end
    mem_busy = 1'b0;
    k = 0;
    while (dbg_state !== MEM_FETCH && k < 20) begin
      tick();
      k++;
    end
    total++;
    if (k != WAIT_CYC + 1) begin
      bad++; $display("FAIL slow_read_latency: %0d cycles, required %0d", k, WAIT_CYC + 1);
    end
    wait_retires(3, "slow_read_rest");
    check_queue_empty("slow_read_write");
  endtask

  task automatic test_slow_write;
    begin_prog();
    mem_busy = 1'b1;
    rom[0] = 16'h4000;
    rom[1] = c16(1'b0, 6'b111010, 3'b001, 3'b000); // M=-1
    rom[2] = 16'd2;
    rom[3] = c16(1'b0, 6'b101010, 3'b000, 3'b111); // 0;JMP
    exp_q.push_back({16'h4000, 16'hFFFF});
    release_reset();
    wait_state(WRITE_BACK, "slow_write_enter");
    for (int i = 0; i < 3; i++) begin
      total += 2;
      if (mem_we !== 1'b0) begin
        bad++; $display("FAIL slow_write_stall_we: %b, required 0", mem_we);
      end
      if (dbg_state !== WRITE_BACK) begin
        bad++; $display("FAIL slow_write_stall_state: %0d, required WRITE_BACK", dbg_state);
      end
      tick();
    end
    mem_busy = 1'b0;
    wait_retires(1, "slow_write_retire");
    check_queue_empty("slow_write_write");
  endtask

  task automatic test_jump;
    begin_prog();
    rom[0]  = 16'd10;
    rom[1]  = c16(1'b0, 6'b101010, 3'b000, 3'b111); // 0;JMP
    rom[10] = 16'd20;
    rom[11] = c16(1'b0, 6'b101010, 3'b010, 3'b010); // D=0;JEQ
    rom[20] = 16'd30;
    rom[21] = c16(1'b0, 6'b111111, 3'b010, 3'b010); // D=1;JEQ
    rom[22] = 16'd0;
    rom[23] = c16(1'b0, 6'b001100, 3'b001, 3'b000); // M=D
    rom[24] = 16'd24;
    rom[25] = c16(1'b0, 6'b101010, 3'b000, 3'b111); // 0;JMP
    exp_q.push_back({16'h0000, 16'd1});
    release_reset();
    wait_retires(2, "jmp_retire");
    total += 2;
    if (pc !== 16'd10) begin bad++; $display("FAIL jmp_pc: %h, required 000a", pc); end
    if (dbg_state !== FETCH) begin bad++; $display("FAIL jmp_fetch: %0d, required FETCH", dbg_state); end
    tick();
    total++;
    if (dbg_state !== DECODE) begin bad++; $display("FAIL jmp_one_fetch: %0d, required DECODE", dbg_state); end
    wait_retires(2, "jeq_taken_retire");
    total++;
    if (pc !== 16'd20) begin bad++; $display("FAIL jeq_taken_pc: %h, required 0014", pc); end
    wait_retires(2, "jeq_not_taken_retire");
    total++;
    if (pc !== 16'd22) begin bad++; $display("FAIL jeq_not_taken_pc: %h, required 0016", pc); end
    wait_retires(2, "jump_tail");
    check_queue_empty("jump_write");
  endtask

  task automatic test_halt;
    int k;
    begin_prog();
    rom[0] = 16'd3;
    rom[1] = c16(1'b0, 6'b110111, 3'b010, 3'b000); // D=A+1
    rom[2] = 16'd0;
    rom[3] = c16(1'b0, 6'b001100, 3'b001, 3'b000); // M=D
    rom[4] = 16'd4;
    rom[5] = c16(1'b0, 6'b101010, 3'b000, 3'b111); // 0;JMP
    exp_q.push_back({16'h0000, 16'd4});
    release_reset();
    wait_state(WRITE_BACK, "halt_wb");
    halt_req = 1'b1;
    k = 0;
    while (halted !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    total += 3;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt_enter: halted=%b, required 1", halted); end
    if (dbg_state !== HALT) begin bad++; $display("FAIL halt_state: %0d, required HALT", dbg_state); end
    if (pc !== HALT_PC) begin bad++; $display("FAIL halt_pc: %h, required %h", pc, HALT_PC); end
    repeat (4) begin
      tick();
      total += 2;
      if (pc !== HALT_PC) begin bad++; $display("FAIL halt_pc_hold: %h, required %h", pc, HALT_PC); end
      if (halted !== 1'b1) begin bad++; $display("FAIL halt_hold: %b, required 1", halted); end
    end
    halt_req = 1'b0;
    tick();
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL halt_release: %b, required 0", halted); end
    repeat (20) tick();
    check_queue_empty("halt_write");
  endtask

  task automatic test_reset_abandon;
    begin_prog();
    mem_busy = 1'b1;
    rom[0] = 16'h4000;
    rom[1] = c16(1'b0, 6'b111010, 3'b001, 3'b000); // M=-1
    release_reset();
    wait_state(WRITE_BACK, "abandon_wb");
    tick();
    reset    = 1'b1;
    mem_busy = 1'b0;
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL abandon_we: %b, required 0", mem_we); end
    tick();
    total += 2;
    if (dbg_state !== FETCH) begin bad++; $display("FAIL abandon_state: %0d, required FETCH", dbg_state); end
    if (pc !== 16'd0) begin bad++; $display("FAIL abandon_pc: %h, required 0000", pc); end
    rom[0] = 16'd0;
    rom[1] = c16(1'b0, 6'b101010, 3'b000, 3'b111); // 0;JMP
    release_reset();
    wait_retires(4, "abandon_loop");
    check_queue_empty("abandon_no_write");
  endtask

  task automatic test_wide_wrap;
    int got;
    int k;
    reset24 = 1'b0;
    got = 0;
    k = 0;
    while (got < 2 && k < 40) begin
      tick();
      k++;
      if (retire24 === 1'b1) got++;
    end
    total += 2;
    if (got != 2) begin bad++; $display("FAIL wide_retire: %0d, required 2", got); end
    if (pc24 !== 24'hFFFFFF) begin bad++; $display("FAIL wide_jeq_pc: %h, required ffffff", pc24); end
    k = 0;
    while (we24 !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    total += 2;
    if (addr24 !== 24'hFFFFFF) begin bad++; $display("FAIL wide_addr: %h, required ffffff", addr24); end
    if (we24 !== 1'b1 || wdata24 !== 24'd0) begin
      bad++; $display("FAIL wide_wrap_d: we=%b wdata=%h, required we=1 wdata=000000", we24, wdata24);
    end
    reset24 = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    reset     = 1'b1;
    mem_busy  = 1'b0;
    mem_rdata = 16'h0000;
    halt_req  = 1'b0;
    reset24   = 1'b1;
    busy24    = 1'b0;
    rdata24   = 24'd0;
    halt24    = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;

    test_reset();
    test_basic_alu();
    test_slow_read();
    test_slow_write();
    test_jump();
    test_halt();
    test_reset_abandon();
    reset = 1'b1;
    test_wide_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hack_core.md
HACK_CORE -- requirements
Module: hack_core

Interface
REQ-001 Parameter DATA_W, default 16: word width of instruction, A, D, PC and memory data; must be at least 16.
REQ-002 Parameter SLOW_BASE, default 16'h4000: lowest address of the slow (shared) memory region.
REQ-003 Parameter SLOW_LIMIT, default 16'h5FFF: highest address of the slow region, inclusive.
REQ-004 Parameter WAIT_CYCLES, default 2: settle cycles after mem_busy falls before slow read data is valid; range 0..7.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 instr  input  DATA_W  ROM word at address pc, valid one cycle after pc changes.
REQ-008 mem_busy  input  1  slow region currently owned by another master.
REQ-009 mem_rdata  input  DATA_W  memory read data for mem_addr.
REQ-010 halt_req  input  1  request to stop at the next instruction boundary.
REQ-011 mem_we  output  1  write strobe, one cycle per committed write.
REQ-012 mem_addr  output  DATA_W  always equals the A register.
REQ-013 mem_wdata  output  DATA_W  ALU result.
REQ-014 pc  output  DATA_W  ROM fetch address (registered).
REQ-015 retire  output  1  one-cycle pulse per completed instruction.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 States: FETCH, DECODE, MEM_READ, MEM_FETCH, WRITE_BACK, HALT.
REQ-018 FETCH: halt_req high -> HALT; else -> DECODE.
REQ-019 HALT: halted=1; pc, A, D held; halt_req low -> FETCH.
REQ-020 DECODE, instr[DATA_W-1]=0 (A-instr): A <= instr; retire=1 next cycle; pc <= pc+1 (mod 2^DATA_W); -> FETCH.
REQ-021 DECODE, C-instr: latch c=instr[11:6], d=instr[5:3], j=instr[2:0]; alu_x <= D; pc <= pc+1; instr[12]=1 -> MEM_READ, else alu_y <= A and -> WRITE_BACK; bits [DATA_W-2:13] ignored.
REQ-022 Slow access: SLOW_BASE <= mem_addr <= SLOW_LIMIT; otherwise fast.
REQ-023 MEM_READ, fast: -> MEM_FETCH next cycle.
REQ-024 MEM_READ, slow: wait until mem_busy=0, then WAIT_CYCLES further cycles (mem_busy ignored during count), then -> MEM_FETCH.
REQ-025 MEM_FETCH: alu_y <= mem_rdata; clear wait counter; -> WRITE_BACK.
REQ-026 WRITE_BACK commits when d3=0, or fast, or mem_busy=0; otherwise stalls with no register, pc or memory change.
REQ-027 On commit: d1 -> A <= alu; d2 -> D <= alu; d3 -> mem_we=1 that cycle at the pre-update A address; retire=1 next cycle.
REQ-028 mem_we is 0 in every stall cycle and every non-commit state.
REQ-029 jump = (j1 & neg) | (j2 & zero) | (j3 & !neg & !zero); on commit jump -> pc <= A (value before d1 update), next FETCH.
REQ-030 ALU: Hack semantics (zx,nx,zy,ny,f,no) at DATA_W bits; add wraps mod 2^DATA_W; neg = MSB.
REQ-031 Latency (fast, no jump, spec fetch on): A-instr 2 cycles, C non-memory 2, C memory read 4; jump +1.

Reset
REQ-032 Reset: A, D, pc, alu_x, alu_y, wait counter = 0; state FETCH; mem_we, retire, halted = 0.
REQ-033 Reset in any state, including a stalled WRITE_BACK or slow MEM_READ, abandons the instruction with no write.

Configuration
REQ-034 Macro HACK_CORE_SPEC_FETCH_EN defined: non-jumping commit -> DECODE (speculative next instruction used).
REQ-035 Macro undefined: every commit -> FETCH; C non-memory latency becomes 3 cycles; results otherwise identical.

Structure
REQ-036 Package hack_pkg holds state enum, instruction field bit positions and jump-bit constants.
REQ-037 Sub-module hack_alu (parameter DATA_W) holds the combinational ALU with zero/neg flags.

Verification
REQ-038 @5 ; D=A ; @7 ; D=D+A ; @0 ; M=D -> mem_we once, addr 0, wdata 12, D=12.
REQ-039 @16384 ; D=M with mem_busy high 5 cycles -> MEM_FETCH exactly WAIT_CYCLES+1 cycles after busy falls; D=mem_rdata.
REQ-040 @16384 ; M=-1 with mem_busy high 3 cycles -> no mem_we while busy; single mem_we with wdata all ones.
REQ-041 @10 ; 0;JMP -> pc=10 after commit, one FETCH cycle, next retire is ROM[10]; D=0;JEQ taken, D=1;JEQ not taken.
REQ-042 halt_req mid C-instr -> instruction completes, HALT entered at next FETCH, halted=1, pc unchanged until release.
REQ-043 DATA_W=24: @ max A value then D=A+1 -> D wraps to 0, zero flag set.
